// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL reset pulse, lock qualification, clkout0 gating and staggered domain-reset release.
// Build option PLL_SEQ_AUTO_RELOCK_EN: lock loss in GATE/RUN restarts the sequence instead of latching FAIL.
module pll_lock_seq #(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 100,
    parameter int STABLE_CYCLES = 16,
    parameter int NUM_DOM       = 3,
    parameter int DOM_STAGGER   = 4,
    parameter int MAX_RETRY     = 3,
    parameter int RETRY_W       = $clog2(MAX_RETRY + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock_i,
    input  logic               restart_i,
    output logic               pll_rst_o,
    output logic               clkout0_gate_o,
    output logic [NUM_DOM-1:0] dom_rst_n_o,
    output logic               seq_done_o,
    output logic               seq_fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [2:0]         state_o
);

    localparam int REL_CYCLES = NUM_DOM * DOM_STAGGER;
    localparam int MAX_AB     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD     = (STABLE_CYCLES > REL_CYCLES) ? STABLE_CYCLES : REL_CYCLES;
    localparam int MAX_ALL    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W      = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REL_LAST    = CNT_W'(REL_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_GATE   = 3'd3,
        S_RUN    = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

`ifdef PLL_SEQ_AUTO_RELOCK_EN
    localparam state_t LOSS_STATE = S_RST;
`else
    localparam state_t LOSS_STATE = S_FAIL;
`endif

    logic [1:0]         sync_q;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d;
    logic               gate_q, gate_d;
    logic [NUM_DOM-1:0] dom_q, dom_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic               lock_s;

    assign lock_s = sync_q[1];

    // Next-state, shared counter and retry bookkeeping; restart overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        retry_d = retry_q;
        if (restart_i) begin
            state_d = S_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RST;
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        retry_d = retry_q + RETRY_ONE;
                        cnt_d   = '0;
                        if ((retry_q + RETRY_ONE) == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_RST;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_GATE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_STABLE;
                    end
                end
                S_GATE: begin
                    if (!lock_s) begin
                        state_d = LOSS_STATE;
                        cnt_d   = '0;
                    end else if (cnt_q == REL_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        state_d = S_GATE;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_d = LOSS_STATE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = cnt_q;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                    cnt_d   = cnt_q;
                end
                default: begin
                    state_d = S_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output values for the state being entered, so every output is a plain register.
    always_comb begin
        pll_rst_d = (state_d == S_RST) || (state_d == S_FAIL);
        gate_d    = (state_d == S_GATE) || (state_d == S_RUN);
        done_d    = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
        dom_d     = '0;
        case (state_d)
            S_RUN: begin
                dom_d = '1;
            end
            S_GATE: begin
                // Bit i releases once (i+1)*DOM_STAGGER edges have passed since GATE entry.
                if (state_q == S_GATE) begin
                    for (int i = 0; i < NUM_DOM; i++) begin
                        dom_d[i] = (int'(cnt_q) + 1) >= ((i + 1) * DOM_STAGGER);
                    end
                end else begin
                    dom_d = '0;
                end
            end
            default: begin
                dom_d = '0;
            end
        endcase
    end

    // Lock synchroniser, FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            state_q   <= S_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            gate_q    <= 1'b0;
            dom_q     <= '0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pll_lock_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            gate_q    <= gate_d;
            dom_q     <= dom_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst_o      = pll_rst_q;
    assign clkout0_gate_o = gate_q;
    assign dom_rst_n_o    = dom_q;
    assign seq_done_o     = done_q;
    assign seq_fail_o     = fail_q;
    assign retry_cnt_o    = retry_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq: directed scenarios with literal timing checks, then random lock/restart
// traffic, all compared each cycle against a phase/elapsed-time model of the sequencer.
module tb_pll_lock_seq;

    localparam int RST_CYCLES    = 8;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 16;
    localparam int NUM_DOM       = 3;
    localparam int DOM_STAGGER   = 4;
    localparam int MAX_RETRY     = 3;

    localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_GATE = 3, P_RUN = 4, P_FAIL = 5;
    localparam int SEL_PLL_RST = 0, SEL_GATE = 1, SEL_FAIL = 2, SEL_DOM = 3, SEL_DONE = 4, SEL_STATE = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, gate, done, fail;
    logic [2:0] dom;
    logic [1:0] retry;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_lock_seq #(
        .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
        .NUM_DOM(NUM_DOM), .DOM_STAGGER(DOM_STAGGER), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock), .restart_i(restart),
        .pll_rst_o(pll_rst), .clkout0_gate_o(gate), .dom_rst_n_o(dom),
        .seq_done_o(done), .seq_fail_o(fail), .retry_cnt_o(retry), .state_o(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus cycles elapsed in it, lock seen through a two-sample delay line.
    int m_phase = P_RST;
    int m_t     = 0;
    int m_retry = 0;
    bit m_l1    = 1'b0;
    bit m_l2    = 1'b0;

    function automatic int exp_dom();
        int v = 0;
        if (m_phase == P_RUN) v = 7;
        if (m_phase == P_GATE)
            for (int i = 0; i < NUM_DOM; i++) if (m_t >= (i + 1) * DOM_STAGGER) v += (1 << i);
        return v;
    endfunction

    task automatic lose_lock();
`ifdef PLL_SEQ_AUTO_RELOCK_EN
        m_phase = P_RST;
`else
        m_phase = P_FAIL;
`endif
        m_t = 0;
    endtask

    always @(posedge clk) begin : model_and_compare
        bit ls;
        if (!rst_n) begin
            m_phase = P_RST; m_t = 0; m_retry = 0; m_l1 = 1'b0; m_l2 = 1'b0;
        end else begin
            ls   = m_l2;
            m_l2 = m_l1;
            m_l1 = pll_lock;
            if (restart) begin
                m_phase = P_RST; m_t = 0; m_retry = 0;
            end else begin
                case (m_phase)
                    P_RST: begin
                        m_t++;
                        if (m_t == RST_CYCLES) begin m_phase = P_WAIT; m_t = 0; end
                    end
                    P_WAIT: begin
                        if (ls) begin
                            m_phase = P_STABLE; m_t = 0;
                        end else begin
                            m_t++;
                            if (m_t == LOCK_TIMEOUT) begin
                                m_retry++;
                                m_phase = (m_retry == MAX_RETRY) ? P_FAIL : P_RST;
                                m_t = 0;
                            end
                        end
                    end
                    P_STABLE: begin
                        if (!ls) begin
                            m_phase = P_WAIT; m_t = 0;
                        end else begin
                            m_t++;
                            if (m_t == STABLE_CYCLES) begin m_phase = P_GATE; m_t = 0; end
                        end
                    end
                    P_GATE: begin
                        if (!ls) lose_lock();
                        else begin
                            m_t++;
                            if (m_t == NUM_DOM * DOM_STAGGER) begin m_phase = P_RUN; m_t = 0; m_retry = 0; end
                        end
                    end
                    P_RUN: if (!ls) lose_lock();
                    default: ;
                endcase
            end
        end
        #1;
        check("m_pll_rst", pll_rst, (m_phase == P_RST || m_phase == P_FAIL) ? 1 : 0);
        check("m_gate", gate, (m_phase == P_GATE || m_phase == P_RUN) ? 1 : 0);
        check("m_dom", dom, exp_dom());
        check("m_done", done, (m_phase == P_RUN) ? 1 : 0);
        check("m_fail", fail, (m_phase == P_FAIL) ? 1 : 0);
        check("m_retry", retry, m_retry);
        check("m_state", state, m_phase);
    end

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            SEL_PLL_RST: return {31'd0, pll_rst};
            SEL_GATE:    return {31'd0, gate};
            SEL_FAIL:    return {31'd0, fail};
            SEL_DOM:     return {29'd0, dom};
            SEL_DONE:    return {31'd0, done};
            default:     return {29'd0, state};
        endcase
    endfunction

    // Counts rising edges until the probed output equals val; -1 if the budget runs out.
    task automatic count_until(input int sel, input logic [31:0] val, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (probe(sel) === val) begin n = k; break; end
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk); restart = 1'b1;
        @(posedge clk); #1;
        check("restart_state", state, P_RST);
        check("restart_retry", retry, 0);
        check("restart_fail", fail, 0);
        check("restart_pll_rst", pll_rst, 1);
        @(negedge clk); restart = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"}, pll_rst, 1);
        check({tag, "_gate"}, gate, 0);
        check({tag, "_dom"}, dom, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_retry"}, retry, 0);
        check({tag, "_state"}, state, P_RST);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hold;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // Nominal power-up.
        rst_n = 1'b1;
        count_until(SEL_PLL_RST, 0, 50, n);    check("t1_rst_len", n, 8);
        repeat (20) @(negedge clk);
        pll_lock = 1'b1;
        count_until(SEL_GATE, 1, 100, n);      check("t1_gate_lat", n, 19);
        check("t1_dom_at_gate", dom, 0);
        count_until(SEL_DOM, 1, 20, n);        check("t1_dom0", n, 4);
        count_until(SEL_DOM, 3, 20, n);        check("t1_dom1", n, 4);
        count_until(SEL_DOM, 7, 20, n);        check("t1_dom2", n, 4);
        check("t1_done", done, 1);
        check("t1_retry", retry, 0);

        // Lock loss in RUN.
        repeat (5) @(negedge clk);
        pll_lock = 1'b0;
        count_until(SEL_GATE, 0, 20, n);       check("t4_loss_lat", n, 3);
        check("t4_dom", dom, 0);
        check("t4_done", done, 0);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
        check("t4_pll_rst", pll_rst, 1);
        check("t4_state", state, P_RST);
        count_until(SEL_PLL_RST, 0, 50, n);    check("t4_relock_rst_len", n, 8);
`else
        check("t4_fail", fail, 1);
        check("t4_state", state, P_FAIL);
        repeat (20) @(negedge clk);
        check("t4_fail_held", state, P_FAIL);
`endif

        // Restart, one timeout, restart mid-WAIT, then run out of retries.
        pulse_restart();
        count_until(SEL_PLL_RST, 0, 50, n);    check("t5_rst_len", n, 8);
        count_until(SEL_PLL_RST, 1, 200, n);   check("t3_timeout_len", n, 100);
        check("t3_retry1", retry, 1);
        count_until(SEL_PLL_RST, 0, 50, n);    check("t3_rst_len2", n, 8);
        repeat (30) @(negedge clk);
        pulse_restart();
        count_until(SEL_FAIL, 1, 500, n);      check("t3_fail_lat", n, 324);
        check("t3_retry3", retry, 3);
        check("t3_pll_rst", pll_rst, 1);
        check("t3_state", state, P_FAIL);
        repeat (10) @(negedge clk);
        pulse_restart();

        // Lock glitch during STABLE.
        count_until(SEL_PLL_RST, 0, 50, n);    check("t2_rst_len", n, 8);
        repeat (20) @(negedge clk);
        pll_lock = 1'b1;
        repeat (10) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        count_until(SEL_GATE, 1, 100, n);      check("t2_gate_lat", n, 19);
        count_until(SEL_DONE, 1, 50, n);       check("t2_done_lat", n, 12);

        // Asynchronous reset mid-GATE.
        pulse_restart();
        count_until(SEL_GATE, 1, 100, n);      check("t6_gate_reached", gate, 1);
        repeat (5) @(negedge clk);
        check("t6_dom_partial", dom, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("t6_async");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Random lock behaviour with occasional restarts.
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            restart = ($urandom_range(0, 499) == 0);
            if (hold == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    pll_lock = 1'b1; hold = $urandom_range(20, 300);
                end else begin
                    pll_lock = 1'b0; hold = $urandom_range(1, 150);
                end
            end else begin
                hold--;
            end
        end
        @(negedge clk);
        restart = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
